mxrv_ex_stage: RTL
==================

// Module: mxrv_ex_stage
// PURPOSE
//  Parametrised, handshaked RV32I/RV64I integer execute stage between decode and writeback.
//  Covers OP-IMM, OP and LUI. One-entry registered result. Optional iterative divider (M-ext DIV/REM).
//  Stall and flush come from the control unit.
// PARAMETERS
//  XLEN    32  datapath width; 32 or 64 only
//  REG_AW  5   register address width
//  SHW     $clog2(XLEN)  shift-amount width (localparam, derived)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       decode presents an op
//  in_ready   out  1       stage accepts op when in_valid & in_ready
//  opcode_i   in   7       instruction opcode
//  funct3_i   in   3       funct3
//  funct7_i   in   7       funct7; bit5 selects SUB/SRA/SRAI
//  rd_i       in   REG_AW  destination register
//  rs1_data_i in   XLEN    rs1 value
//  rs2_data_i in   XLEN    rs2 value
//  imm_i      in   XLEN    sign-extended immediate (LUI: already shifted)
//  flush_i    in   1       kill in-flight op and result
//  out_valid  out  1       result valid
//  out_ready  in   1       writeback consumes result
//  out_rd     out  REG_AW  destination of result
//  out_data   out  XLEN    result value
//  out_wr_en  out  1       write rd (0 when rd==0 or illegal)
//  out_illegal out 1       unsupported opcode/funct combination
//  div_busy_o out  1       divider iterating
// BEHAVIOUR
//  Reset: out_valid=0, out_rd=0, out_data=0, out_wr_en=0, out_illegal=0, div_busy_o=0, FSM=IDLE.
//  in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush_i.
//  FSM: IDLE -> DIV on accepted DIV/DIVU/REM/REMU with nonzero divisor and no signed overflow.
//    DIV counts XLEN iterations, then loads output register and returns to IDLE.
//  ALU ops: accepted at edge N, out_valid high after edge N (1-cycle latency).
//  Divide: out_valid high XLEN+1 cycles after acceptance edge; div_busy_o high throughout DIV.
//  Output held stable while out_valid & ~out_ready. Cleared on out_ready unless a new op loads the same edge.
//  Arithmetic: all results modulo 2^XLEN. Shifts use operand[SHW-1:0].
//    SLT/SLTI are signed compares; SLTU/SLTIU are unsigned. Result is 0/1 zero-extended.
//  XLEN=64: no W-variants; *W opcodes are illegal.
//  Div by zero (1-cycle): DIV/DIVU -> all ones; REM/REMU -> rs1.
//  Overflow, DIV of min / -1 (1-cycle): DIV -> min; REM -> 0.
//  Signed division: quotient sign = sign(rs1)^sign(rs2); remainder sign = sign(rs1).
//  Illegal/unknown opcode: completes in 1 cycle with out_illegal=1, out_wr_en=0, out_data=0.
//  rd_i==0: result produced normally, out_wr_en=0.
//  flush_i: out_valid cleared next edge; divider aborted, FSM->IDLE; nothing accepted that cycle.
//    Flush wins over simultaneous completion.
//  rst mid-division: identical to reset values; partial quotient discarded.
// CONFIGURATION
//  MXRV_EX_DIV_EN defined: funct7=0000001 with funct3 100..111 executes DIV/DIVU/REM/REMU.
//    funct3 000..011 (MUL*) is illegal.
//  MXRV_EX_DIV_EN undefined: all funct7=0000001 ops are illegal; div_busy_o tied 0.
//    FSM never leaves IDLE; no divider instantiated.
// STRUCTURE
//  mxrv_pkg: opcode constants (OP_IMM, OP, LUI), funct3 encodings, funct7 ALT/MULDIV values.
//    Also holds the FSM state typedef.
//  Sub-module mxrv_div_iter: radix-2 restoring unsigned divider with start/abort/done.
//    Signs and special cases are handled in mxrv_ex_stage.
// TESTING
//  ADDI rs1=0x7FFFFFFF imm=1 rd=5 -> next cycle out_data=0x80000000, out_wr_en=1, out_rd=5.
//  SRA rs1=0x80000000 rs2=0x24 -> out_data=0xF8000000 (shift 4). SLTU 1 vs 0xFFFFFFFF -> out_data=1.
//  DIV rs1=-7 rs2=2 -> div_busy_o for 32 cycles, out_valid at +33, out_data=-3.
//    REM same operands -> out_data=-1.
//  DIVU by 0 -> 1-cycle, 0xFFFFFFFF. DIV 0x80000000 / -1 -> 0x80000000, 1-cycle.
//  out_ready=0 for 5 cycles after result -> in_ready=0, out_data stable. Then a b2b ADD stream -> 1 op/cycle.
//  flush_i at DIV cycle 10 -> out_valid never rises, div_busy_o=0 next cycle, next ADD completes normally.
//    Build without MXRV_EX_DIV_EN: DIV -> out_illegal=1, out_wr_en=0.

Source files
------------

// File: rtl/mxrv_pkg.sv
// mxrv_pkg: shared encodings for the mxrv execute stage.
// Opcode/funct constants and the execute FSM state type.
package mxrv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    S_IDLE,
    S_DIV
  } ex_state_t;

endpackage

// File: rtl/mxrv_div_iter.sv
// mxrv_div_iter: radix-2 restoring unsigned divider, one bit per cycle.
// quotient/remainder show the next step; valid as the final result when done.
module mxrv_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic          busy;
  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    trial;

  always_comb begin
    trial = {rem_q, quo_q[W-1]};
    if (trial >= {1'b0, dvs_q}) begin
      remainder = W'(trial - {1'b0, dvs_q});
      quotient  = {quo_q[W-2:0], 1'b1};
    end else begin
      remainder = trial[W-1:0];
      quotient  = {quo_q[W-2:0], 1'b0};
    end
  end

  // The W-th step is consumed combinationally by the stage
  assign done = busy & (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mxrv_ex_stage.sv
// mxrv_ex_stage: RV32I/RV64I OP-IMM/OP/LUI execute stage, one-entry result.
// Define MXRV_EX_DIV_EN to add iterative DIV/DIVU/REM/REMU.
module mxrv_ex_stage
  import mxrv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_data,
  output logic              out_wr_en,
  output logic              out_illegal,
  output logic              div_busy_o
);

  localparam int SHW = $clog2(XLEN);

  ex_state_t         state_q, state_d;
  logic              accept, illegal, slow, div_done;
  logic              is_op, is_imm;
  logic [6:0]        f7m;
  logic [SHW-1:0]    sh;
  logic [XLEN-1:0]   opb, res, sra, div_res;
  logic [REG_AW-1:0] div_rd;

  assign in_ready = (state_q == S_IDLE)
                  & (~out_valid | out_ready) & ~flush_i;
  assign accept = in_valid & in_ready;
  assign is_op  = opcode_i == OP;
  assign is_imm = opcode_i == OP_IMM;
  assign opb    = is_op ? rs2_data_i : imm_i;
  assign sh     = opb[SHW-1:0];
  assign sra    = $signed(rs1_data_i) >>> sh;

  // On RV64 funct7[0] of a shift-immediate is shamt[5]
  always_comb begin
    f7m = funct7_i;
    if (XLEN == 64) f7m[0] = 1'b0;
  end

`ifdef MXRV_EX_DIV_EN
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            is_div, sgn, is_rem, neg_a, neg_b;
  logic            dz, ovf, start;
  logic            p_rem, p_neg_q, p_neg_r;
  logic [XLEN-1:0] abs_a, abs_b, quo, rem;

  assign is_div = is_op & (funct7_i == F7_MULDIV) & funct3_i[2];
  assign sgn    = ~funct3_i[0];
  assign is_rem = funct3_i[1];
  assign neg_a  = sgn & rs1_data_i[XLEN-1];
  assign neg_b  = sgn & rs2_data_i[XLEN-1];
  assign abs_a  = neg_a ? -rs1_data_i : rs1_data_i;
  assign abs_b  = neg_b ? -rs2_data_i : rs2_data_i;
  assign dz     = rs2_data_i == '0;
  assign ovf    = sgn & (rs1_data_i == XMIN) & (rs2_data_i == '1);
  assign start  = accept & slow;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_rd  <= '0;
      p_rem   <= 1'b0;
      p_neg_q <= 1'b0;
      p_neg_r <= 1'b0;
    end else if (start) begin
      div_rd  <= rd_i;
      p_rem   <= is_rem;
      p_neg_q <= neg_a ^ neg_b;
      p_neg_r <= neg_a;
    end
  end

  mxrv_div_iter #(.W(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (flush_i),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  assign div_res = p_rem ? (p_neg_r ? -rem : rem)
                         : (p_neg_q ? -quo : quo);
  assign div_busy_o = state_q == S_DIV;
`else
  assign div_done   = 1'b0;
  assign div_res    = '0;
  assign div_rd     = '0;
  assign div_busy_o = 1'b0;
`endif

  always_comb begin
    illegal = 1'b1;
    slow    = 1'b0;
    res     = '0;
    unique case (funct3_i)
      F3_ADD:  res = (is_op & funct7_i[5]) ? rs1_data_i - opb
                                           : rs1_data_i + opb;
      F3_SLL:  res = rs1_data_i << sh;
      F3_SLT:  res = XLEN'($signed(rs1_data_i) < $signed(opb));
      F3_SLTU: res = XLEN'(rs1_data_i < opb);
      F3_XOR:  res = rs1_data_i ^ opb;
      F3_SR:   res = funct7_i[5] ? sra : rs1_data_i >> sh;
      F3_OR:   res = rs1_data_i | opb;
      F3_AND:  res = rs1_data_i & opb;
    endcase
    unique case (1'b1)
      opcode_i == LUI: begin
        illegal = 1'b0;
        res     = imm_i;
      end
      is_imm: begin
        if (funct3_i == F3_SLL)
          illegal = f7m != F7_BASE;
        else if (funct3_i == F3_SR)
          illegal = !(f7m == F7_BASE || f7m == F7_ALT);
        else
          illegal = 1'b0;
      end
      is_op: illegal = !(funct7_i == F7_BASE
                     || (funct7_i == F7_ALT
                     && (funct3_i == F3_ADD || funct3_i == F3_SR)));
      default: ;
    endcase
`ifdef MXRV_EX_DIV_EN
    if (is_div) begin
      illegal = 1'b0;
      if (dz)       res = is_rem ? rs1_data_i : '1;
      else if (ovf) res = is_rem ? '0 : XMIN;
      else          slow = 1'b1;
    end
`endif
    if (illegal) res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && slow) state_d = S_DIV;
      S_DIV:  if (flush_i || div_done) state_d = S_IDLE;
    endcase
  end

  // Flush beats a same-edge divider completion
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_data    <= '0;
      out_wr_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (div_done) begin
      out_valid   <= 1'b1;
      out_rd      <= div_rd;
      out_data    <= div_res;
      out_wr_en   <= div_rd != '0;
      out_illegal <= 1'b0;
    end else if (accept && !slow) begin
      out_valid   <= 1'b1;
      out_rd      <= rd_i;
      out_data    <= res;
      out_wr_en   <= !illegal && rd_i != '0;
      out_illegal <= illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_data    <= '0;
      out_wr_en   <= 1'b0;
      out_illegal <= 1'b0;
    end
  end

endmodule
